// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, RV32I opcodes and the decode control bundle.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       zero_a;
    logic       writes_rd;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_control.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU op and operand-select controls.
module alu_control
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '{alu_op: ALU_NOP, use_imm: 1'b0, zero_a: 1'b0, writes_rd: 1'b0, illegal: 1'b1};
    case (opcode_i)
      OP_R, OP_I: begin
        ctrl_o.use_imm   = (opcode_i == OP_I);
        ctrl_o.writes_rd = 1'b1;
        ctrl_o.illegal   = 1'b0;
        case (funct3_i)
          3'b000:  ctrl_o.alu_op = (opcode_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b100:  ctrl_o.alu_op = ALU_XOR;
          3'b110:  ctrl_o.alu_op = ALU_OR;
          3'b111:  ctrl_o.alu_op = ALU_AND;
          3'b010:  ctrl_o.alu_op = ALU_SLT;
          default: begin
            ctrl_o.alu_op    = ALU_NOP;
            ctrl_o.use_imm   = 1'b0;
            ctrl_o.writes_rd = 1'b0;
            ctrl_o.illegal   = 1'b1;
          end
        endcase
      end
      OP_LOAD, OP_STORE: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.writes_rd = (opcode_i == OP_LOAD);
        ctrl_o.illegal   = 1'b0;
      end
      OP_BRANCH: begin
        ctrl_o.alu_op  = ALU_SUB;
        ctrl_o.illegal = 1'b0;
      end
      OP_LUI: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.zero_a    = 1'b1;
        ctrl_o.writes_rd = 1'b1;
        ctrl_o.illegal   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode to ALU op, forward from MEM/WB, register operands
// behind a valid/ready handshake with stall and flush.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_illegal
);

  ctrl_t                 ctrl;
  logic                  valid_q;
  logic [XLEN-1:0]       a_q, a_d, b_q, b_d, sd_q, src1, src2;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  ill_q;
  logic                  capture;

  alu_control u_alu_control (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_5_i(funct7_5),
    .ctrl_o    (ctrl)
  );

  // x0 always reads zero; MEM is the younger producer so it wins over WB.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_ADDR_W-1:0] rs,
                                          input logic [XLEN-1:0]       rf_data);
    if (rs == '0)                            return '0;
    else if (mem_wr_en && mem_rd == rs)      return mem_result;
    else if (wb_wr_en && wb_rd == rs)        return wb_result;
    else                                     return rf_data;
  endfunction

  always_comb begin
    src1 = fwd(rs1, rs1_data);
    src2 = fwd(rs2, rs2_data);
    a_d  = (ctrl.illegal || ctrl.zero_a) ? '0 : src1;
    b_d  = ctrl.illegal ? '0 : (ctrl.use_imm ? imm : src2);
    rd_d = ctrl.writes_rd ? rd : '0;
  end

  assign in_ready = reset || !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sd_q    <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= ctrl.alu_op;
      sd_q    <= src2;
      rd_q    <= rd_d;
      ill_q   <= ctrl.illegal;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign store_data  = sd_q;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, handshake corner sequences, random scoreboard.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd, out_rd;
  logic [31:0] rs1_data, rs2_data, imm, mem_result, wb_result;
  logic        mem_wr_en, wb_wr_en, out_illegal;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } stim_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int unsigned pass_cnt = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, got, want, $time);
  endtask

  function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                               input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im);
    stim_t s;
    s.opcode = op; s.funct3 = f3; s.f7 = f7; s.rs1 = r1; s.rs2 = r2; s.rd = d;
    s.d1 = v1; s.d2 = v2; s.imm = im;
    s.mwe = 1'b0; s.mrd = 5'd0; s.mres = 32'hDEAD0001;
    s.wwe = 1'b0; s.wrd = 5'd0; s.wres = 32'hDEAD0002;
    return s;
  endfunction

  function automatic exp_t mke(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                               input logic [31:0] sd, input logic [4:0] d, input logic il);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.sd = sd; e.rd = d; e.ill = il;
    return e;
  endfunction

  // Reference model: architectural reading of the instruction, not the RTL structure.
  function automatic logic [31:0] ref_src(input stim_t s, input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (s.mwe && s.mrd == r) return s.mres;
    if (s.wwe && s.wrd == r) return s.wres;
    return rf;
  endfunction

  function automatic exp_t ref_model(input stim_t s);
    exp_t e;
    logic [31:0] x1, x2;
    logic ok;
    x1 = ref_src(s, s.rs1, s.d1);
    x2 = ref_src(s, s.rs2, s.d2);
    ok = 1'b1;
    e.sd = x2; e.ill = 1'b0;
    e.a = 32'd0; e.b = 32'd0; e.op = 4'hF; e.rd = 5'd0;
    if (s.opcode == 7'b0110011 || s.opcode == 7'b0010011) begin
      e.a  = x1;
      e.b  = (s.opcode == 7'b0010011) ? s.imm : x2;
      e.rd = s.rd;
      if (s.funct3 == 3'b000)      e.op = (s.opcode == 7'b0110011 && s.f7) ? 4'd2 : 4'd0;
      else if (s.funct3 == 3'b100) e.op = 4'd6;
      else if (s.funct3 == 3'b110) e.op = 4'd5;
      else if (s.funct3 == 3'b111) e.op = 4'd4;
      else if (s.funct3 == 3'b010) e.op = 4'd10;
      else ok = 1'b0;
    end else if (s.opcode == 7'b0000011) begin
      e.a = x1; e.b = s.imm; e.op = 4'd0; e.rd = s.rd;
    end else if (s.opcode == 7'b0100011) begin
      e.a = x1; e.b = s.imm; e.op = 4'd0; e.rd = 5'd0;
    end else if (s.opcode == 7'b1100011) begin
      e.a = x1; e.b = x2; e.op = 4'd2; e.rd = 5'd0;
    end else if (s.opcode == 7'b0110111) begin
      e.a = 32'd0; e.b = s.imm; e.op = 4'd0; e.rd = s.rd;
    end else ok = 1'b0;
    if (!ok) begin
      e.a = 32'd0; e.b = 32'd0; e.op = 4'hF; e.rd = 5'd0; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input stim_t s);
    opcode = s.opcode; funct3 = s.funct3; funct7_5 = s.f7;
    rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; rs1_data = s.d1; rs2_data = s.d2; imm = s.imm;
    mem_wr_en = s.mwe; mem_rd = s.mrd; mem_result = s.mres;
    wb_wr_en = s.wwe; wb_rd = s.wrd; wb_result = s.wres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string nm, input exp_t e);
    chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, ".a"}, alu_a, e.a);
    chk({nm, ".b"}, alu_b, e.b);
    chk({nm, ".op"}, {28'd0, alu_op}, {28'd0, e.op});
    chk({nm, ".sd"}, store_data, e.sd);
    chk({nm, ".rd"}, {27'd0, out_rd}, {27'd0, e.rd});
    chk({nm, ".ill"}, {31'd0, out_illegal}, {31'd0, e.ill});
  endtask

  vec_t  vecs[$];
  stim_t sx, sy, sz;
  exp_t  ey, exp_q;
  logic  exp_valid;

  initial begin
    vec_t v;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));

    // Directed table: stimulus with hand-derived expectations.
    v.s = mk(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    v.e = mke(32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0110011, 3'b000, 1'b0, 5'd3, 5'd4, 5'd5, 32'd1, 32'd9, 32'd0);
    v.s.mwe = 1'b1; v.s.mrd = 5'd3; v.s.mres = 32'hAAAA;
    v.s.wwe = 1'b1; v.s.wrd = 5'd3; v.s.wres = 32'hBBBB;
    v.e = mke(32'hAAAA, 32'd9, 4'b0000, 32'd9, 5'd5, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd4, 5'd5, 32'h77, 32'd9, 32'd0);
    v.s.mwe = 1'b1; v.s.mrd = 5'd0; v.s.mres = 32'hAAAA;
    v.e = mke(32'd0, 32'd9, 4'b0000, 32'd9, 5'd5, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd6, 32'd10, 32'd3, 32'd0);
    v.e = mke(32'd10, 32'd3, 4'b0010, 32'd3, 5'd6, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'hFFFFFFFF);
    v.e = mke(32'd1, 32'hFFFFFFFF, 4'b0000, 32'd2, 5'd7, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0010011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd8, 32'd3, 32'd2, 32'd4);
    v.e = mke(32'd3, 32'd4, 4'b1010, 32'd2, 5'd8, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd9, 32'd99, 32'd2, 32'h12345000);
    v.e = mke(32'd0, 32'h12345000, 4'b0000, 32'd2, 5'd9, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd10, 32'd100, 32'h55, 32'd8);
    v.e = mke(32'd100, 32'd8, 4'b0000, 32'h55, 5'd0, 1'b0); vecs.push_back(v);
    v.s = mk(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd11, 32'd6, 32'd7, 32'd12);
    v.e = mke(32'd0, 32'd0, 4'b1111, 32'd7, 5'd0, 1'b1); vecs.push_back(v);
    v.s = mk(7'b0110011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd12, 32'd6, 32'd7, 32'd0);
    v.e = mke(32'd0, 32'd0, 4'b1111, 32'd7, 5'd0, 1'b1); vecs.push_back(v);
    v.s = mk(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd13, 32'd4, 32'd4, 32'd16);
    v.e = mke(32'd4, 32'd4, 4'b0010, 32'd4, 5'd0, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0110011, 3'b100, 1'b0, 5'd1, 5'd6, 5'd14, 32'd15, 32'd3, 32'd0);
    v.s.wwe = 1'b1; v.s.wrd = 5'd6; v.s.wres = 32'h1234;
    v.s.mwe = 1'b1; v.s.mrd = 5'd7; v.s.mres = 32'hAAAA;
    v.e = mke(32'd15, 32'h1234, 4'b0110, 32'h1234, 5'd14, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd9, 32'h1000, 32'd2, 32'd4);
    v.e = mke(32'h1000, 32'd4, 4'b0000, 32'd2, 5'd9, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0010011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd3, 32'hF0, 32'd2, 32'h0F);
    v.e = mke(32'hF0, 32'h0F, 4'b0101, 32'd2, 5'd3, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0010011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hF0, 32'd2, 32'hFF);
    v.e = mke(32'hF0, 32'hFF, 4'b0100, 32'd2, 5'd3, 1'b0); vecs.push_back(v);
    v.s = mk(7'b0010011, 3'b101, 1'b0, 5'd1, 5'd2, 5'd3, 32'hF0, 32'd2, 32'hFF);
    v.e = mke(32'd0, 32'd0, 4'b1111, 32'd2, 5'd0, 1'b1); vecs.push_back(v);

    // Reset state.
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    chk("reset.valid", {31'd0, out_valid}, 32'd0);
    chk("reset.a", alu_a, 32'd0);
    chk("reset.op", {28'd0, alu_op}, 32'd0);
    chk("reset.rd", {27'd0, out_rd}, 32'd0);
    chk("reset.ill", {31'd0, out_illegal}, 32'd0);
    reset = 1'b0;

    // Back-to-back table vectors with out_ready held high.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s);
      in_valid = 1'b1;
      step();
      chk_entry($sformatf("vec%0d", i), vecs[i].e);
    end
    in_valid = 1'b0;
    step();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // Stall: held entry stays put while a new one is offered.
    sx = mk(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    sy = mk(7'b0110011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd4, 32'h3C, 32'h0F, 32'd0);
    ey = mke(32'h3C, 32'h0F, 4'b0100, 32'h0F, 5'd4, 1'b0);
    drive(sx); in_valid = 1'b1; out_ready = 1'b1;
    step();
    drive(sy); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
      step();
      chk_entry($sformatf("stall%0d", c), mke(32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_entry("unstall", ey);

    // Flush during a stall discards both held and offered entries.
    sz = mk(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd3);
    drive(sz); out_ready = 1'b0;
    step();
    chk("ill_held.ill", {31'd0, out_illegal}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("ill_cap.ill", {31'd0, out_illegal}, 32'd1);
    drive(sy); out_ready = 1'b0; flush = 1'b1;
    step();
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.ill", {31'd0, out_illegal}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_nocap.valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall.
    drive(sx); in_valid = 1'b1;
    step();
    in_valid = 1'b1; out_ready = 1'b0; reset = 1'b1;
    #1;
    chk("rststall.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("rststall.valid", {31'd0, out_valid}, 32'd0);
    chk("rststall.a", alu_a, 32'd0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Random traffic against the scoreboard.
    exp_valid = 1'b0;
    exp_q = mke(32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      logic [6:0] ops[8];
      logic exp_ready;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b1101111, 7'b0010111};
      s = mk(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, $urandom);
      s.mwe = 1'($urandom_range(0, 1)); s.mrd = 5'($urandom_range(0, 3)); s.mres = $urandom;
      s.wwe = 1'($urandom_range(0, 1)); s.wrd = 5'($urandom_range(0, 3)); s.wres = $urandom;
      drive(s);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !exp_valid || out_ready;
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (flush) begin
        exp_valid = 1'b0;
        exp_q.ill = 1'b0;
      end else if (in_valid && exp_ready) begin
        exp_valid = 1'b1;
        exp_q = ref_model(s);
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      step();
      chk("rnd.valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) chk_entry("rnd", exp_q);
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
